fast_pack: RTL and testbench



---
 rtl/fast_link_pkg.sv | 29 ++
 rtl/fast_pack_buf.sv | 33 +++
 rtl/fast_pack.sv | 126 ++++++++++++
 tb/tb_fast_pack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_link_pkg.sv
// Shared constants, serializer state type and packing helpers for the fast
// telemetry byte link (packer and extractor).
package fast_link_pkg;

  localparam int FRAME_BYTES = 14;
  localparam int DATA_BYTES  = 12;
  localparam int GRP_BYTES   = 3;
  localparam int GRP_WORDS   = 4;
  localparam int WORD_W      = 6;
  localparam int BYTE_W      = 8;

  localparam logic [BYTE_W-1:0] PAD0_DEF = 8'h00;
  localparam logic [BYTE_W-1:0] PAD1_DEF = 8'h00;

  typedef enum logic [1:0] {IDLE, LOAD, HIGH, LOW} serState_t;

  // Pack w0..w3 into {C, B, A}; A sits in the low byte so it leaves first.
  function automatic logic [GRP_BYTES*BYTE_W-1:0] packGroup(
    input logic [GRP_WORDS-1:0][WORD_W-1:0] w
  );
    return {w[3][5:4], w[2], w[3][3:2], w[1], w[3][1:0], w[0]};
  endfunction

  // Frame byte indices that carry byte A of a group.
  function automatic logic isGrpStart(input logic [3:0] idx);
    return (idx == 4'd1) || (idx == 4'd4) || (idx == 4'd7) || (idx == 4'd10);
  endfunction

endpackage

// File: rtl/fast_pack_buf.sv
// Four-word collection buffer: fills in arrival order, reports full, and is
// emptied in one cycle when the serializer takes the group.
module fast_pack_buf
  import fast_link_pkg::*;
(
  input  logic                              clk80,
  input  logic                              reset,
  input  logic [WORD_W-1:0]                 wrData,
  input  logic                              wrEn,
  input  logic                              clear,
  output logic [GRP_WORDS-1:0][WORD_W-1:0]  words,
  output logic                              full
);

  logic [2:0] fillCnt;
  logic       accept;

  assign full   = (fillCnt == 3'(GRP_WORDS));
  assign accept = wrEn && !full;

  // Fill counter; clear wins, and only ever arrives while full so no write collides.
  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset)      fillCnt <= '0;
    else if (clear)  fillCnt <= '0;
    else if (accept) fillCnt <= fillCnt + 3'd1;
  end

  // Word storage; contents are only consumed once all four slots are written.
  always_ff @(posedge clk80) begin
    if (accept) words[fillCnt[1:0]] <= wrData;
  end

endmodule

// File: rtl/fast_pack.sv
// Transmit-side packer: groups of four 6-bit words become three link bytes,
// 14-byte frames (4 groups + 2 pads), each byte sent with a stretched strobe.
module fast_pack
  import fast_link_pkg::*;
#(
  parameter int                HI_CYC = 4,
  parameter int                LO_CYC = 4,
  parameter logic [BYTE_W-1:0] PAD0   = PAD0_DEF,
  parameter logic [BYTE_W-1:0] PAD1   = PAD1_DEF
)(
  input  logic              clk80,
  input  logic              reset,
  input  logic [WORD_W-1:0] iData,
  input  logic              iVal,
  output logic              oRdy,
  output logic [BYTE_W-1:0] oData,
  output logic              oVal,
  output logic              oFrm
);

  serState_t                         state, stateNext;
  logic [3:0]                        dlyCnt, dlyCntNext;
  logic [3:0]                        frmIdx, frmIdxNext;
  logic [GRP_WORDS-1:0][WORD_W-1:0]  bufWords;
  logic                              bufFull;
  logic                              grpXfer;
  logic                              isPad;
  logic [GRP_BYTES*BYTE_W-1:0]       txReg;
  logic [BYTE_W-1:0]                 curByte;

  fast_pack_buf uBuf (
    .clk80  (clk80),
    .reset  (reset),
    .wrData (iData),
    .wrEn   (iVal),
    .clear  (grpXfer),
    .words  (bufWords),
    .full   (bufFull)
  );

  assign oRdy  = !bufFull;
  assign isPad = (frmIdx > 4'(DATA_BYTES));

  always_comb begin
    curByte = txReg[BYTE_W-1:0];
    if (frmIdx == 4'(DATA_BYTES + 1))      curByte = PAD0;
    else if (frmIdx == 4'(FRAME_BYTES))    curByte = PAD1;
  end

  // Serializer next state: pads go out unconditionally, data waits for a full group.
  always_comb begin
    stateNext  = state;
    dlyCntNext = dlyCnt;
    frmIdxNext = frmIdx;
    grpXfer    = 1'b0;
    unique case (state)
      IDLE: begin
        if (isPad) begin
          stateNext = LOAD;
        end else if (bufFull) begin
          stateNext = LOAD;
          grpXfer   = isGrpStart(frmIdx);
        end
      end
      LOAD: begin
        stateNext  = HIGH;
        dlyCntNext = '0;
      end
      HIGH: begin
        if (dlyCnt == 4'(HI_CYC - 1)) begin
          stateNext  = LOW;
          dlyCntNext = '0;
        end else begin
          dlyCntNext = dlyCnt + 4'd1;
        end
      end
      LOW: begin
        if (dlyCnt == 4'(LO_CYC - 1)) begin
          frmIdxNext = (frmIdx == 4'(FRAME_BYTES)) ? 4'd1 : frmIdx + 4'd1;
          stateNext  = isGrpStart(frmIdxNext) ? IDLE : LOAD;
        end else begin
          dlyCntNext = dlyCnt + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Serializer state, delay counter and frame byte index.
  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      dlyCnt <= '0;
      frmIdx <= 4'd1;
    end else begin
      state  <= stateNext;
      dlyCnt <= dlyCntNext;
      frmIdx <= frmIdxNext;
    end
  end

  // Link outputs: byte and strobe launch as LOAD is left, strobe drops at end of HIGH.
  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset) begin
      oData <= '0;
      oVal  <= 1'b0;
      oFrm  <= 1'b0;
    end else begin
      oFrm <= 1'b0;
      if (state == LOAD) begin
        oData <= curByte;
        oVal  <= 1'b1;
        oFrm  <= (frmIdx == 4'd1);
      end else if (state == HIGH && stateNext == LOW) begin
        oVal  <= 1'b0;
      end
    end
  end

  // Group output register: loaded on transfer, shifted as each data byte launches.
  always_ff @(posedge clk80) begin
    if (grpXfer)                      txReg <= packGroup(bufWords);
    else if (state == LOAD && !isPad) txReg <= txReg >> BYTE_W;
  end

endmodule

// File: tb/tb_fast_pack.sv
// Scoreboard bench for fast_pack: stimulus queues expected link bytes, a
// negedge monitor checks each byte as its strobe rises.
module tb_fast_pack;

  localparam int HI_CYC = 4;
  localparam int LO_CYC = 4;
  localparam int PERIOD = HI_CYC + LO_CYC + 1;

  typedef struct {
    logic [7:0] data;
    logic       frm;
    int         gap;
    bit         chk;
  } exp_t;

  logic       clk80;
  logic       reset;
  logic [5:0] iData;
  logic       iVal;
  logic       oRdy;
  logic [7:0] oData;
  logic       oVal;
  logic       oFrm;

  exp_t       expQ[$];
  logic [7:0] rxQ[$];
  int         compares = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         riseCnt  = 0;
  int         lastRise = -1;
  int         frmRiseCyc = -1;
  int         hiCnt    = 0;
  logic       prevVal  = 1'b0;
  int         lastStrobeCyc = 0;

  fast_pack #(
    .HI_CYC (HI_CYC),
    .LO_CYC (LO_CYC),
    .PAD0   (8'h00),
    .PAD1   (8'h00)
  ) dut (
    .clk80 (clk80),
    .reset (reset),
    .iData (iData),
    .iVal  (iVal),
    .oRdy  (oRdy),
    .oData (oData),
    .oVal  (oVal),
    .oFrm  (oFrm)
  );

  initial begin
    clk80 = 1'b0;
    forever #5 clk80 = ~clk80;
  end

  always @(posedge clk80) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    compares++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: one scoreboard pop per strobe rise, plus strobe shape checks.
  always @(negedge clk80) begin
    exp_t e;
    if (!reset) begin
      prevVal  = 1'b0;
      hiCnt    = 0;
      lastRise = -1;
    end else begin
      if (oVal && !prevVal) begin
        riseCnt++;
        if (expQ.size() == 0) begin
          cmp("unexpected_byte", {24'd0, oData}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          if (e.chk) cmp("byte", {24'd0, oData}, {24'd0, e.data});
          else       rxQ.push_back(oData);
          cmp("frm", {31'd0, oFrm}, {31'd0, e.frm});
          if (e.frm) frmRiseCyc = cyc;
          if (e.gap != 0) cmp("period", cyc - lastRise, e.gap);
        end
        lastRise = cyc;
        hiCnt    = 1;
      end else if (oVal) begin
        hiCnt++;
      end else if (prevVal) begin
        cmp("high_len", hiCnt, HI_CYC);
      end
      if (oFrm && !(oVal && !prevVal)) cmp("stray_frm", {31'd0, oFrm}, 32'd0);
      prevVal = oVal;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk80);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d, input logic f, input int gap, input bit chk);
    exp_t e;
    e.data = d; e.frm = f; e.gap = gap; e.chk = chk;
    expQ.push_back(e);
  endtask

  task automatic pushGroup(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic f, input bit chk);
    pushByte(a, f, 0, chk);
    pushByte(b, 1'b0, PERIOD, chk);
    pushByte(c, 1'b0, PERIOD, chk);
  endtask

  task automatic pushPads();
    pushByte(8'h00, 1'b0, PERIOD, 1'b1);
    pushByte(8'h00, 1'b0, PERIOD, 1'b1);
  endtask

  // One strobe; optionally waits (bounded) for room first.
  task automatic sendWord(input logic [5:0] w, input bit waitRdy);
    int n = 0;
    if (waitRdy) begin
      while (!oRdy && n < 400) begin tick(1); n++; end
      if (n >= 400) cmp("rdy_timeout", {31'd0, oRdy}, 32'd1);
    end
    iData = w;
    iVal  = 1'b1;
    @(posedge clk80);
    #1;
    lastStrobeCyc = cyc;
    iVal = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || oVal) && n < budget) begin tick(1); n++; end
    if (n >= budget) cmp("drain_timeout", expQ.size(), 0);
    tick(LO_CYC + 2);
  endtask

  task automatic doReset();
    reset = 1'b0;
    expQ.delete();
    tick(3);
    @(negedge clk80);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    logic [5:0] rw[16];
    logic [7:0] a, b, c;
    int strobe4, base, n, idleRise;

    reset = 1'b0;
    iData = '0;
    iVal  = 1'b0;
    tick(3);
    cmp("rst_oData", {24'd0, oData}, 32'd0);
    cmp("rst_oVal",  {31'd0, oVal},  32'd0);
    cmp("rst_oFrm",  {31'd0, oFrm},  32'd0);
    cmp("rst_oRdy",  {31'd0, oRdy},  32'd1);
    @(negedge clk80);
    reset = 1'b1;
    tick(2);

    // Basic group: 01 02 03 3F -> C1 C2 C3, frame start
    pushGroup(8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b1);
    sendWord(6'h01, 1'b1);
    sendWord(6'h02, 1'b1);
    sendWord(6'h03, 1'b1);
    sendWord(6'h3F, 1'b1);
    strobe4 = lastStrobeCyc;
    cmp("rdy_full", {31'd0, oRdy}, 32'd0);
    tick(1);
    cmp("rdy_back", {31'd0, oRdy}, 32'd1);
    drain(200);
    cmp("first_latency", frmRiseCyc - strobe4, 2);

    // Busy serializer, then a burst of 5: the 5th is dropped
    pushGroup(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
    pushGroup(8'h51, 8'h62, 8'h73, 1'b0, 1'b1);
    sendWord(6'h0A, 1'b1);
    sendWord(6'h0B, 1'b1);
    sendWord(6'h0C, 1'b1);
    sendWord(6'h00, 1'b1);
    tick(3);
    cmp("burst_rdy1", {31'd0, oRdy}, 32'd1); sendWord(6'h11, 1'b0);
    cmp("burst_rdy2", {31'd0, oRdy}, 32'd1); sendWord(6'h22, 1'b0);
    cmp("burst_rdy3", {31'd0, oRdy}, 32'd1); sendWord(6'h33, 1'b0);
    cmp("burst_rdy4", {31'd0, oRdy}, 32'd1); sendWord(6'h15, 1'b0);
    cmp("burst_rdy5", {31'd0, oRdy}, 32'd0); sendWord(6'h3F, 1'b0);
    drain(400);

    // Last group of the frame, then pads with no further input
    pushGroup(8'hBC, 8'h85, 8'hAB, 1'b0, 1'b1);
    pushPads();
    sendWord(6'h3C, 1'b1);
    sendWord(6'h05, 1'b1);
    sendWord(6'h2B, 1'b1);
    sendWord(6'h2A, 1'b1);
    drain(400);
    idleRise = riseCnt;
    tick(30);
    cmp("idle_oVal", {31'd0, oVal}, 32'd0);
    cmp("idle_rises", riseCnt, idleRise);

    // Full frame of 2A words, then the next group restarts the frame
    for (int g = 0; g < 4; g++) pushGroup(8'hAA, 8'hAA, 8'hAA, (g == 0), 1'b1);
    pushPads();
    pushGroup(8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) sendWord(6'h2A, 1'b1);
    sendWord(6'h01, 1'b1);
    sendWord(6'h02, 1'b1);
    sendWord(6'h03, 1'b1);
    sendWord(6'h3F, 1'b1);
    drain(1000);

    // Reset during byte 2 of group 2, with two words already buffered
    pushGroup(8'h15, 8'h2A, 8'h3F, 1'b0, 1'b1);
    base = riseCnt;
    sendWord(6'h15, 1'b1);
    sendWord(6'h2A, 1'b1);
    sendWord(6'h3F, 1'b1);
    sendWord(6'h00, 1'b1);
    n = 0;
    while (riseCnt < base + 2 && n < 200) begin tick(1); n++; end
    if (n >= 200) cmp("abort_wait", riseCnt, base + 2);
    sendWord(6'h01, 1'b1);
    sendWord(6'h02, 1'b1);
    #2;
    cmp("abort_pre_oVal", {31'd0, oVal}, 32'd1);
    reset = 1'b0;
    #1;
    cmp("abort_oVal", {31'd0, oVal}, 32'd0);
    expQ.delete();
    tick(2);
    @(negedge clk80);
    reset = 1'b1;
    tick(2);
    cmp("abort_oRdy", {31'd0, oRdy}, 32'd1);
    pushGroup(8'hC4, 8'hC8, 8'hD0, 1'b1, 1'b1);
    sendWord(6'h04, 1'b1);
    sendWord(6'h08, 1'b1);
    sendWord(6'h10, 1'b1);
    sendWord(6'h3F, 1'b1);
    drain(200);

    // Round trip: 16 random words, unpacked from the link bytes
    doReset();
    rxQ.delete();
    for (int g = 0; g < 4; g++) pushGroup(8'h00, 8'h00, 8'h00, (g == 0), 1'b0);
    pushPads();
    for (int i = 0; i < 16; i++) begin
      rw[i] = 6'($urandom_range(0, 63));
      sendWord(rw[i], 1'b1);
    end
    drain(1000);
    cmp("rx_count", rxQ.size(), 12);
    if (rxQ.size() == 12) begin
      for (int g = 0; g < 4; g++) begin
        a = rxQ[3*g]; b = rxQ[3*g+1]; c = rxQ[3*g+2];
        cmp("extract_w0", {26'd0, a[5:0]}, {26'd0, rw[4*g]});
        cmp("extract_w1", {26'd0, b[5:0]}, {26'd0, rw[4*g+1]});
        cmp("extract_w2", {26'd0, c[5:0]}, {26'd0, rw[4*g+2]});
        cmp("extract_w3", {26'd0, c[7:6], b[7:6], a[7:6]}, {26'd0, rw[4*g+3]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
